spi_master: RTL

- System-clock SPI master, mode 0 (CPOL=0, CPHA=0), single chip-select. Companion initiator for the team's SPI slave.
- Takes a parallel word over a valid/ready handshake, frames it with CS, generates SCL, shifts MOSI out MSB-first and captures MISO into a parallel word.
- Each frame starts with a fixed number of dummy SCL cycles, giving the slave its load phase before the data bits.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clk_div.sv | 23 ++
 rtl/spi_master.sv | 111 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared state encoding and default geometry for the SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LEAD,
    SHIFT,
    HOLD,
    GAP
  } spi_mst_state_t;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_CLK_DIV     = 2;
  localparam int DEF_LEAD_CYCLES = 2;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: counts 0..CLK_DIV-1 and pulses tick on the last count.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (clr || tick) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: frames a parallel word with CS, leading dummy SCL cycles,
// MSB-first MOSI shift and MISO capture on each data rise.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int LEAD_CYCLES = DEF_LEAD_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  SCL,
  output logic                  CS,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int HC_MAX = 2 * ((LEAD_CYCLES > DATA_WIDTH) ? LEAD_CYCLES : DATA_WIDTH);
  localparam int HW     = $clog2(HC_MAX + 1);

  spi_mst_state_t        state, next_state;
  logic                  tick, clr, accept, rdy_q, hc_last, rise;
  logic [HW-1:0]         hcnt;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift;

  // The final GAP tick also offers ready so a queued frame follows with minimum CS-high time.
  assign tx_ready = rdy_q || ((state == GAP) && tick);
  assign accept   = tx_valid && tx_ready;
  assign clr      = rst || (state == IDLE) || (next_state != state);
  assign rise     = !hcnt[0];

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    hc_last = 1'b0;
    if (state == LEAD)       hc_last = (int'(hcnt) == 2 * LEAD_CYCLES - 1);
    else if (state == SHIFT) hc_last = (int'(hcnt) == 2 * DATA_WIDTH - 1);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   if (tick) next_state = (LEAD_CYCLES > 0) ? LEAD : SHIFT;
      LEAD:    if (tick && hc_last) next_state = SHIFT;
      SHIFT:   if (tick && hc_last) next_state = HOLD;
      HOLD:    if (tick) next_state = GAP;
      GAP:     if (tick) next_state = accept ? SETUP : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hcnt     <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rdy_q    <= 1'b0;
      busy     <= 1'b0;
      SCL      <= 1'b0;
      CS       <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      state    <= next_state;
      rdy_q    <= (next_state == IDLE);
      busy     <= (next_state != IDLE);
      rx_valid <= 1'b0;

      if (clr)       hcnt <= '0;
      else if (tick) hcnt <= hcnt + 1'b1;

      if (accept) begin
        tx_shift <= tx_data;
        MOSI     <= tx_data[DATA_WIDTH-1];
        CS       <= 1'b0;
      end

      // Even half-ticks raise SCL, odd ones lower it; only SHIFT moves data.
      if (tick && ((state == LEAD) || (state == SHIFT))) begin
        SCL <= rise;
        if ((state == SHIFT) && rise)
          rx_shift <= {rx_shift[DATA_WIDTH-2:0], MISO};
        if ((state == SHIFT) && !rise && !hc_last) begin
          tx_shift <= tx_shift << 1;
          MOSI     <= tx_shift[DATA_WIDTH-2];
        end
      end

      if ((state == HOLD) && tick) begin
        CS       <= 1'b1;
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        MOSI     <= 1'b0;
      end
    end
  end

endmodule
